// File: rtl/quantum_pkg.sv
// rtl/quantum_pkg.sv - shared fixed-point constants, FSM encoding and LFSR helpers
//
// Purpose: common definitions for the quantum measurement blocks.
//   FP_*       : Q8.8 constants
//   state_t    : bell_measurement FSM encoding
//   LFSR_TAPS  : Fibonacci taps 16,14,13,11 as a bit mask
//   lfsr_next  : one left-shift step of the 16-bit LFSR
package quantum_pkg;

  localparam logic [15:0] FP_ONE       = 16'h0100;
  localparam logic [15:0] FP_ZERO      = 16'h0000;
  localparam logic [15:0] FP_INV_SQRT2 = 16'h00B5;

  // Taps 16,14,13,11 map to bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CNOT   = 3'd1,
    ST_HAD    = 3'd2,
    ST_PROB   = 3'd3,
    ST_SAMPLE = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/bell_prob_unit.sv
// rtl/bell_prob_unit.sv - saturated squared magnitude of one Q8.8 amplitude
//
// Purpose: prob = (re*re >>> 8) + (im*im >>> 8), saturated to 16'hFFFF.
// Ports:
//   re, im  in  16  signed Q8.8 amplitude
//   prob    out 16  unsigned Q8.8 probability
module bell_prob_unit (
  input  logic signed [15:0] re,
  input  logic signed [15:0] im,
  output logic        [15:0] prob
);

  logic signed [31:0] re_sq;
  logic signed [31:0] im_sq;
  logic        [23:0] sum;
  logic        [17:0] square_unused;

  assign re_sq = re * re;
  assign im_sq = im * im;

  // Squares are non-negative and at most 2^30, so bit 31 is always zero and
  // the shifted value fits in bits 30:8.
  assign sum = {1'b0, re_sq[30:8]} + {1'b0, im_sq[30:8]};
  assign square_unused = {re_sq[31], re_sq[7:0], im_sq[31], im_sq[7:0]};

  assign prob = (|sum[23:16]) ? 16'hFFFF : sum[15:0];

endmodule

// File: rtl/fixed_point_add.sv
// rtl/fixed_point_add.sv - 16-bit two's complement add/subtract with wrap
//
// Purpose: Q8.8 add or subtract; overflow wraps.
// Ports:
//   a, b    in  16  operands
//   sub     in  1   0: a+b, 1: a-b
//   result  out 16  wrapped result
module FixedPoint_Add (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sub,
  output logic [15:0] result
);

  assign result = sub ? (a - b) : (a + b);

endmodule

// File: rtl/fixed_point_multiply.sv
// rtl/fixed_point_multiply.sv - signed Q8.8 multiply, truncating
//
// Purpose: signed 32-bit product, arithmetic shift right 8, low 16 bits kept.
// Ports:
//   a, b    in  16  signed Q8.8 operands
//   result  out 16  signed Q8.8 product (wraps on overflow)
module FixedPoint_Multiply (
  input  logic signed [15:0] a,
  input  logic signed [15:0] b,
  output logic        [15:0] result
);

  logic signed [31:0] product;
  logic        [15:0] product_unused;

  assign product = a * b;
  // (product >>> 8) truncated to 16 bits is exactly bits 23:8.
  assign result         = product[23:8];
  assign product_unused = {product[31:24], product[7:0]};

endmodule

// File: rtl/bell_measurement.sv
// rtl/bell_measurement.sv - Bell-basis measurement: CNOT, Hadamard, probabilities, sampling
//
// Purpose: takes a 2-qubit Q8.8 state, applies CNOT(q0->q1) then H on q0,
// computes the four basis probabilities and draws a 2-bit outcome from an
// internal LFSR.
// Ports:
//   clk, reset            clock, async active-high reset
//   in_valid/in_ready     input handshake (ready only in IDLE)
//   in_cXY_re/_im         signed Q8.8 amplitudes, X = qubit 0
//   out_valid/out_ready   result handshake (valid held until taken)
//   outcome               Bell index 00=Phi+, 01=Psi+, 10=Phi-, 11=Psi-
//   prob00..prob11        unsigned Q8.8 probabilities
module bell_measurement
  import quantum_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_c00_re,
  input  logic [15:0] in_c00_im,
  input  logic [15:0] in_c01_re,
  input  logic [15:0] in_c01_im,
  input  logic [15:0] in_c10_re,
  input  logic [15:0] in_c10_im,
  input  logic [15:0] in_c11_re,
  input  logic [15:0] in_c11_im,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  outcome,
  output logic [15:0] prob00,
  output logic [15:0] prob01,
  output logic [15:0] prob10,
  output logic [15:0] prob11
);

  // Index 0..3 = basis 00, 01, 10, 11.
  state_t      state_q, state_d;
  logic [15:0] in_re      [4];
  logic [15:0] in_im      [4];
  logic [15:0] amp_re     [4];
  logic [15:0] amp_im     [4];
  logic [15:0] had_re     [4];
  logic [15:0] had_im     [4];
  logic [15:0] sum_re     [2];
  logic [15:0] dif_re     [2];
  logic [15:0] sum_im     [2];
  logic [15:0] dif_im     [2];
  logic [15:0] prob_calc  [4];
  logic [15:0] prob_q     [4];
  logic [15:0] prob_out   [4];
  logic [15:0] lfsr;
  logic [1:0]  outcome_q, outcome_d;
  logic        accept;

  logic [17:0] total, cum0, cum1, cum2, target;
  logic [33:0] scaled;
  logic [15:0] scaled_unused;

  assign in_re[0] = in_c00_re;
  assign in_im[0] = in_c00_im;
  assign in_re[1] = in_c01_re;
  assign in_im[1] = in_c01_im;
  assign in_re[2] = in_c10_re;
  assign in_im[2] = in_c10_im;
  assign in_re[3] = in_c11_re;
  assign in_im[3] = in_c11_im;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_valid && in_ready;

  // FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_CNOT;
      ST_CNOT:   state_d = ST_HAD;
      ST_HAD:    state_d = ST_PROB;
      ST_PROB:   state_d = ST_SAMPLE;
      ST_SAMPLE: state_d = ST_DONE;
      ST_DONE:   if (out_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Hadamard on qubit 0 pairs basis states that differ only in qubit 0:
  // (00,10) and (01,11).
  for (genvar g = 0; g < 2; g++) begin : g_had
    FixedPoint_Add u_sum_re (.a(amp_re[g]), .b(amp_re[g+2]), .sub(1'b0), .result(sum_re[g]));
    FixedPoint_Add u_dif_re (.a(amp_re[g]), .b(amp_re[g+2]), .sub(1'b1), .result(dif_re[g]));
    FixedPoint_Add u_sum_im (.a(amp_im[g]), .b(amp_im[g+2]), .sub(1'b0), .result(sum_im[g]));
    FixedPoint_Add u_dif_im (.a(amp_im[g]), .b(amp_im[g+2]), .sub(1'b1), .result(dif_im[g]));

    FixedPoint_Multiply u_mul_sum_re (.a(sum_re[g]), .b(FP_INV_SQRT2), .result(had_re[g]));
    FixedPoint_Multiply u_mul_dif_re (.a(dif_re[g]), .b(FP_INV_SQRT2), .result(had_re[g+2]));
    FixedPoint_Multiply u_mul_sum_im (.a(sum_im[g]), .b(FP_INV_SQRT2), .result(had_im[g]));
    FixedPoint_Multiply u_mul_dif_im (.a(dif_im[g]), .b(FP_INV_SQRT2), .result(had_im[g+2]));
  end

  for (genvar g = 0; g < 4; g++) begin : g_prob
    bell_prob_unit u_prob (.re(amp_re[g]), .im(amp_im[g]), .prob(prob_calc[g]));
  end

  // Outcome draw: scale the LFSR into [0, total) and walk the cumulative sums.
  // A zero total never satisfies t < C, which lands on 11.
  always_comb begin
    total  = {2'b00, prob_q[0]} + {2'b00, prob_q[1]} + {2'b00, prob_q[2]} + {2'b00, prob_q[3]};
    scaled = {18'd0, lfsr} * {16'd0, total};
    target = scaled[33:16];
    cum0   = {2'b00, prob_q[0]};
    cum1   = cum0 + {2'b00, prob_q[1]};
    cum2   = cum1 + {2'b00, prob_q[2]};
    if (target < cum0)      outcome_d = 2'b00;
    else if (target < cum1) outcome_d = 2'b01;
    else if (target < cum2) outcome_d = 2'b10;
    else                    outcome_d = 2'b11;
  end

  assign scaled_unused = scaled[15:0];

  // Datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        amp_re[i]   <= FP_ZERO;
        amp_im[i]   <= FP_ZERO;
        prob_q[i]   <= FP_ZERO;
        prob_out[i] <= FP_ZERO;
      end
      outcome_q <= 2'b00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            for (int i = 0; i < 4; i++) begin
              amp_re[i] <= in_re[i];
              amp_im[i] <= in_im[i];
            end
          end
        end
        ST_CNOT: begin
          // Qubit 0 set flips qubit 1: swap |10> and |11>.
          amp_re[2] <= amp_re[3];
          amp_re[3] <= amp_re[2];
          amp_im[2] <= amp_im[3];
          amp_im[3] <= amp_im[2];
        end
        ST_HAD: begin
          for (int i = 0; i < 4; i++) begin
            amp_re[i] <= had_re[i];
            amp_im[i] <= had_im[i];
          end
        end
        ST_PROB: begin
          for (int i = 0; i < 4; i++) prob_q[i] <= prob_calc[i];
        end
        ST_SAMPLE: begin
          // Visible results change only here, so a partial result is never shown.
          for (int i = 0; i < 4; i++) prob_out[i] <= prob_q[i];
          outcome_q <= outcome_d;
        end
        default: ;
      endcase
    end
  end

  // Free-running LFSR, independent of the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= SEED;
    else       lfsr <= lfsr_next(lfsr);
  end

  assign outcome = outcome_q;
  assign prob00  = prob_out[0];
  assign prob01  = prob_out[1];
  assign prob10  = prob_out[2];
  assign prob11  = prob_out[3];

endmodule

// File: tb/tb_bell_measurement.sv
// tb/tb_bell_measurement.sv - self-checking bench for bell_measurement
module tb_bell_measurement;

  localparam logic [15:0] SEED = 16'hACE1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic [3:0][15:0]  drv_re = '0;
  logic [3:0][15:0]  drv_im = '0;
  logic              in_ready, out_valid;
  logic [1:0]        outcome;
  logic [15:0]       prob00, prob01, prob10, prob11;

  bell_measurement #(.SEED(SEED)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_c00_re(drv_re[0]), .in_c00_im(drv_im[0]),
    .in_c01_re(drv_re[1]), .in_c01_im(drv_im[1]),
    .in_c10_re(drv_re[2]), .in_c10_im(drv_im[2]),
    .in_c11_re(drv_re[3]), .in_c11_im(drv_im[3]),
    .out_valid(out_valid), .out_ready(out_ready), .outcome(outcome),
    .prob00(prob00), .prob01(prob01), .prob10(prob10), .prob11(prob11)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][15:0] re;
    logic [3:0][15:0] im;
    logic [3:0][15:0] exp_p;
    logic             fixed_oc;
    logic [1:0]       exp_oc;
  } vec_t;

  typedef struct packed {
    logic [3:0][15:0] p;
    logic             fixed_oc;
    logic [1:0]       oc;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[10];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Reference LFSR; m_hist is the value held during the previous cycle.
  logic [15:0] m_lfsr, m_hist;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_lfsr <= SEED;
      m_hist <= SEED;
    end else begin
      m_hist <= m_lfsr;
      m_lfsr <= lfsr_step(m_lfsr);
    end
  end

  function automatic logic [15:0] mulk(input logic [15:0] x);
    logic signed [31:0] pr;
    pr = $signed(x) * 32'sd181;
    return pr[23:8];
  endfunction

  function automatic logic [15:0] psq(input logic [15:0] re, input logic [15:0] im);
    logic signed [31:0] a, b;
    logic [31:0] s;
    a = $signed(re) * $signed(re);
    b = $signed(im) * $signed(im);
    s = 32'(a >>> 8) + 32'(b >>> 8);
    return (s > 32'h0000FFFF) ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic [3:0][15:0] model_probs(input logic [3:0][15:0] re, input logic [3:0][15:0] im);
    logic [3:0][15:0] r, i, hr, hi, p;
    logic [15:0] s;
    r = re; i = im;
    r[2] = re[3]; r[3] = re[2];
    i[2] = im[3]; i[3] = im[2];
    for (int k = 0; k < 2; k++) begin
      s = r[k] + r[k+2]; hr[k]   = mulk(s);
      s = r[k] - r[k+2]; hr[k+2] = mulk(s);
      s = i[k] + i[k+2]; hi[k]   = mulk(s);
      s = i[k] - i[k+2]; hi[k+2] = mulk(s);
    end
    for (int k = 0; k < 4; k++) p[k] = psq(hr[k], hi[k]);
    return p;
  endfunction

  function automatic logic [1:0] model_outcome(input logic [3:0][15:0] p, input logic [15:0] l);
    logic [17:0] tot, c0, c1, c2, t;
    logic [33:0] sc;
    tot = {2'b0, p[0]} + {2'b0, p[1]} + {2'b0, p[2]} + {2'b0, p[3]};
    sc  = {18'b0, l} * {16'b0, tot};
    t   = sc[33:16];
    c0  = {2'b0, p[0]};
    c1  = c0 + {2'b0, p[1]};
    c2  = c1 + {2'b0, p[2]};
    if (t < c0) return 2'b00;
    if (t < c1) return 2'b01;
    if (t < c2) return 2'b10;
    return 2'b11;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vector(input vec_t v, input int hold, output logic [1:0] oc_seen);
    int   waitc;
    exp_t e, got;
    logic [65:0] snap;
    waitc = 0;
    while (!in_ready && waitc < 20) begin step(); waitc++; end
    check("in_ready_before_accept", in_ready, 1);
    drv_re = v.re; drv_im = v.im;
    in_valid = 1'b1; out_ready = 1'b0;
    e.p = v.exp_p; e.fixed_oc = v.fixed_oc; e.oc = v.exp_oc;
    sb.push_back(e);
    step();
    in_valid = 1'b0;
    waitc = 0;
    while (!out_valid && waitc < 20) begin step(); waitc++; end
    check("latency", waitc, 4);
    oc_seen = outcome;
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 0, 1);
    end else begin
      got = sb.pop_front();
      check("prob00", prob00, got.p[0]);
      check("prob01", prob01, got.p[1]);
      check("prob10", prob10, got.p[2]);
      check("prob11", prob11, got.p[3]);
      check("outcome_model", outcome, model_outcome(got.p, m_hist));
      if (got.fixed_oc) check("outcome_fixed", outcome, got.oc);
    end
    snap = {outcome, prob00, prob01, prob10, prob11};
    for (int h = 0; h < hold; h++) begin
      step();
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_outputs_stable", {outcome, prob00, prob01, prob10, prob11} != snap, 0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
  endtask

  initial begin
    logic [1:0] oc;
    int r, cnt00, cnt10, first, second, hi_cycles;

    for (int i = 0; i < 10; i++) begin
      tbl[i].re = '0; tbl[i].im = '0; tbl[i].exp_p = '0;
      tbl[i].fixed_oc = 1'b0; tbl[i].exp_oc = 2'b00;
    end
    // Phi+
    tbl[0].re[0] = 16'h00B5; tbl[0].re[3] = 16'h00B5;
    tbl[0].exp_p[0] = 16'h00FE; tbl[0].fixed_oc = 1'b1; tbl[0].exp_oc = 2'b00;
    // Psi-
    tbl[1].re[1] = 16'h00B5; tbl[1].re[2] = 16'hFF4B;
    tbl[1].exp_p[3] = 16'h00FE; tbl[1].fixed_oc = 1'b1; tbl[1].exp_oc = 2'b11;
    // |00>
    tbl[2].re[0] = 16'h0100;
    tbl[2].exp_p[0] = 16'h007F; tbl[2].exp_p[2] = 16'h007F;
    // all zero
    tbl[3].fixed_oc = 1'b1; tbl[3].exp_oc = 2'b11;
    // Phi+ on the imaginary path
    tbl[4].im[0] = 16'h00B5; tbl[4].im[3] = 16'h00B5;
    tbl[4].exp_p[0] = 16'h00FE; tbl[4].fixed_oc = 1'b1; tbl[4].exp_oc = 2'b00;
    // |11>: negative Hadamard difference
    tbl[5].re[3] = 16'h0100;
    tbl[5].exp_p[0] = 16'h007F; tbl[5].exp_p[2] = 16'h007F;
    // saturation
    tbl[6].re[0] = 16'h7FFF; tbl[6].im[0] = 16'h7FFF;
    tbl[6].exp_p[0] = 16'hFFFF; tbl[6].exp_p[2] = 16'hFFFF;
    // random small amplitudes against the model
    for (int i = 7; i < 10; i++) begin
      for (int j = 0; j < 4; j++) begin
        r = int'($urandom_range(400)) - 200; tbl[i].re[j] = r[15:0];
        r = int'($urandom_range(400)) - 200; tbl[i].im[j] = r[15:0];
      end
      tbl[i].exp_p = model_probs(tbl[i].re, tbl[i].im);
    end

    // Reset state
    #2;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_outcome", outcome, 0);
    check("reset_prob00", prob00, 0);
    check("reset_prob01", prob01, 0);
    check("reset_prob10", prob10, 0);
    check("reset_prob11", prob11, 0);
    step(); step();
    reset = 1'b0;

    for (int i = 0; i < 10; i++) run_vector(tbl[i], 0, oc);

    // Back-pressure
    run_vector(tbl[2], 10, oc);

    // Repeated |00> sampling
    cnt00 = 0; cnt10 = 0;
    for (int s = 0; s < 200; s++) begin
      run_vector(tbl[2], 0, oc);
      check("sample_00_or_10", (oc == 2'b00) || (oc == 2'b10), 1);
      if (oc == 2'b00) cnt00++;
      if (oc == 2'b10) cnt10++;
    end
    check("sample_both_seen", (cnt00 > 0) && (cnt10 > 0), 1);

    // Throughput with out_ready tied high
    drv_re = tbl[0].re; drv_im = tbl[0].im;
    in_valid = 1'b1; out_ready = 1'b1;
    first = -1; second = -1;
    for (int c = 1; c <= 30 && second < 0; c++) begin
      step();
      if (out_valid) begin
        check("thru_prob00", prob00, 16'h00FE);
        check("thru_outcome", outcome, 2'b00);
        if (first < 0) first = c;
        else second = c;
      end
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    check("thru_first_latency", first, 5);
    check("thru_spacing", second - first, 6);

    // Reset during the Hadamard step
    drv_re = tbl[6].re; drv_im = tbl[6].im;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    reset = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_outcome", outcome, 0);
    check("abort_probs", {prob00, prob01, prob10, prob11}, 64'd0);
    step(); step();
    reset = 1'b0;
    hi_cycles = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (out_valid) hi_cycles++;
    end
    check("abort_no_result", hi_cycles, 0);
    check("abort_probs_after", {prob00, prob01, prob10, prob11}, 64'd0);
    run_vector(tbl[2], 0, oc);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bell_measurement.md
# bell_measurement

Bell-basis measurement unit: the receiving end of the Bell-state preparation circuit. Accepts a 2-qubit Q8.8 state vector, undoes the entangler by applying CNOT (qubit 0 control, qubit 1 target) and then Hadamard on qubit 0. It then computes the four basis probabilities and draws one classical 2-bit outcome using an internal LFSR. It sits downstream of the preparation circuit and uses valid/ready handshakes on both sides.

## Interface
- SEED, 16'hACE1, LFSR reset value; must be non-zero.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input state vector valid.
- in_ready  out  1  block can accept a vector; high only in IDLE.
- in_cXY_re, in_cXY_im (XY in 00, 01, 10, 11)  in  16 each  signed Q8.8 amplitudes. First index is qubit 0.
- out_valid  out  1  result valid; held until taken.
- out_ready  in  1  consumer accepts result.
- outcome  out  2  measured Bell index: 00=Φ+, 01=Ψ+, 10=Φ−, 11=Ψ−.
- prob00, prob01, prob10, prob11  out  16 each  unsigned Q8.8 probabilities.

## Operation
- Amplitude registers load in_* on in_valid && in_ready.
- FSM states, one cycle each except IDLE and DONE:
  - IDLE → CNOT on accept.
  - CNOT → HAD → PROB → SAMPLE → DONE.
  - DONE → IDLE when out_ready.
- CNOT step: swap c10 and c11, re and im. c00 and c01 are unchanged.
- HAD step on qubit 0:
  - c00' = (c00+c10)·k, c10' = (c00−c10)·k.
  - c01' = (c01+c11)·k, c11' = (c01−c11)·k.
  - k = 16'h00B5.
- Arithmetic:
  - Add/sub are 16-bit two's complement and wrap.
  - Multiply forms a signed 32-bit product, arithmetic shift right 8, keep low 16 bits.
- PROB step: pXY = (re·re >>> 8) + (im·im >>> 8), computed unsigned, saturated to 16'hFFFF.
- SAMPLE step:
  - total = 18-bit sum of the four probabilities.
  - t = (lfsr · total) >> 16.
  - Cumulative sums: C0=p00, C1=C0+p01, C2=C1+p10.
  - outcome = 00 if t<C0, else 01 if t<C1, else 10 if t<C2, else 11.
  - total=0 gives outcome 11.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11, shifting left with feedback into bit 0.
  - Advances every clock outside reset, independent of FSM state.
- prob*/outcome registers update at the SAMPLE→DONE edge and hold until the next completion.

## Timing
- Reset values:
  - state IDLE, in_ready=1, out_valid=0, outcome=00, prob*=0.
  - Amplitude registers 0; lfsr=SEED.
- Latency: accept at edge N → out_valid=1 after edge N+4.
- Throughput: with out_ready tied high, one vector per 6 cycles.
- in_ready is combinational from state; in_valid is ignored outside IDLE.
- out_valid stays high, and outputs stay stable, while out_ready is low.
- Reset mid-operation aborts the transaction: out_valid stays 0, outputs return to reset values, and no partial result is ever presented.

## Structure
- Shared package quantum_pkg holds:
  - FP_ONE=16'h0100, FP_ZERO=16'h0000, FP_INV_SQRT2=16'h00B5.
  - FSM state encoding (3-bit: IDLE, CNOT, HAD, PROB, SAMPLE, DONE).
  - LFSR tap constant.
- Existing FixedPoint_Add and FixedPoint_Multiply are reused for the HAD step.
- One sub-module bell_prob_unit computes a saturated |re|²+|im|², instantiated 4×.

## Test plan
- Φ+ input (c00=c11=0x00B5, others 0) → prob00=0x00FE, other probs 0, outcome=00 for any LFSR value.
- Ψ− input (c01=0x00B5, c10=0xFF4B) → prob11=0x00FE, others 0, outcome=11.
- |00⟩ input (c00_re=0x0100) → prob00=prob10=0x007F, prob01=prob11=0. Over 200 samples, outcome is only 00/10 and matches the reference model bit-exactly for SEED=16'hACE1.
- Hold out_ready=0 for 10 cycles after out_valid → out_valid, outcome and prob* stay stable, in_ready=0. Then raise out_ready → in_ready=1 one cycle later.
- Assert reset during the HAD step → out_valid never rises, outputs return to 0, lfsr=SEED. The next vector completes with normal 4-cycle latency.
- All-zero input → all probs 0, outcome=11.
